// File: rtl/hex_word_tx_formatter_if.sv
// hex_word_tx_formatter_if: FIFO-side, UART-side and status signals of the hex word formatter
interface hex_word_tx_formatter_if;
  logic enable;
  logic fifoEmpty;
  logic [15:0] fifoWord;
  logic fifoReadStrobe;
  logic txActive;
  logic txDone;
  logic txDataValid;
  logic [7:0] txDataByte;
  logic busy;
  logic [15:0] wordsSent;
  modport master(
    input enable, fifoEmpty, fifoWord, txActive, txDone,
    output fifoReadStrobe, txDataValid, txDataByte, busy, wordsSent
  );
  modport slave(
    output enable, fifoEmpty, fifoWord, txActive, txDone,
    input fifoReadStrobe, txDataValid, txDataByte, busy, wordsSent
  );
endinterface

// File: rtl/hex_word_tx_formatter.sv
// hex_word_tx_formatter: reads 16-bit words from a FIFO and sends them to a UART as 4 ASCII hex chars plus optional terminator
module hex_word_tx_formatter #(
  parameter bit UPPERCASE = 1'b1,
  parameter bit TERM_EN = 1'b1,
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input logic clk,
  input logic rst,
  hex_word_tx_formatter_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ENCODE, SEND, WAIT} state_t;
  state_t state, state_nx;
  logic [2:0] idx;
  logic [15:0] word;
  logic [15:0] words_sent;
  logic [7:0] tx_byte;
  logic [3:0] nib;
  logic [7:0] char_nx;
  logic last;
  always_comb begin
    nib = idx == 3'd0 ? word[15:12] : idx == 3'd1 ? word[11:8] : idx == 3'd2 ? word[7:4] : word[3:0];
    char_nx = idx == 3'd4 ? TERM_CHAR :
              nib < 4'd10 ? 8'h30 + {4'h0, nib} :
              (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, nib};
    last = TERM_EN ? idx == 3'd4 : idx == 3'd3;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.enable && !bus.fifoEmpty ? FETCH : IDLE;
      FETCH: state_nx = LATCH;
      LATCH: state_nx = ENCODE;
      ENCODE: state_nx = SEND;
      SEND: state_nx = bus.txActive ? SEND : WAIT;
      WAIT: state_nx = bus.txDone ? (last ? IDLE : ENCODE) : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      word <= '0;
      words_sent <= '0;
      tx_byte <= '0;
    end else begin
      state <= state_nx;
      if (state == LATCH) begin
        word <= bus.fifoWord;
        idx <= '0;
      end
      if (state == ENCODE) tx_byte <= char_nx;
      if (state == WAIT && bus.txDone) begin
        idx <= idx + 3'd1;
        if (last) words_sent <= words_sent + 16'd1;
      end
    end
  end
  // strobe and start pulse are decoded from state so each lasts exactly one cycle
  assign bus.fifoReadStrobe = state == FETCH;
  assign bus.txDataValid = state == SEND && !bus.txActive;
  assign bus.txDataByte = tx_byte;
  assign bus.busy = state != IDLE;
  assign bus.wordsSent = words_sent;
endmodule

// File: doc/hex_word_tx_formatter.md
HEX_WORD_TX_FORMATTER -- requirements
Module: hex_word_tx_formatter

Interface
REQ-001 Parameter UPPERCASE, default 1, meaning: hex letters A-F emitted as 8'h41-8'h46 when 1, as 8'h61-8'h66 when 0.
REQ-002 Parameter TERM_EN, default 1, meaning: append one terminator character after each word when 1.
REQ-003 Parameter TERM_CHAR, default 8'h0A, meaning: terminator byte value.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 enable  input  1  permits fetching of new words; sampled only in IDLE.
REQ-007 fifoEmpty  input  1  read-side FIFO empty flag (standard-mode FIFO).
REQ-008 fifoWord  input  16  FIFO read data; valid the cycle after fifoReadStrobe.
REQ-009 fifoReadStrobe  output  1  single-cycle FIFO read enable.
REQ-010 txActive  input  1  UART transmitter busy.
REQ-011 txDone  input  1  UART transmitter single-cycle completion pulse.
REQ-012 txDataValid  output  1  single-cycle start pulse to UART transmitter.
REQ-013 txDataByte  output  8  byte to transmit; held stable from the txDataValid cycle until txDone.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 wordsSent  output  16  count of fully transmitted words.

Function
REQ-016 The state machine SHALL have states IDLE, FETCH, LATCH, ENCODE, SEND, WAIT.
REQ-017 IDLE -> FETCH when enable=1 and fifoEmpty=0; otherwise the block stays in IDLE.
REQ-018 FETCH: fifoReadStrobe=1 for exactly one cycle -> LATCH.
REQ-019 LATCH: fifoWord captured into an internal 16-bit register; char index reset to 0 -> ENCODE.
REQ-020 ENCODE: txDataByte loaded from the current char index; index 0..3 select nibbles [15:12],[11:8],[7:4],[3:0] (MSB first); index 4 selects TERM_CHAR -> SEND.
REQ-021 Nibble mapping: 0-9 -> 8'h30-8'h39; 10-15 per UPPERCASE.
REQ-022 SEND: txDataValid=1 for one cycle only when txActive=0; while txActive=1, stay in SEND with txDataValid=0 -> WAIT after the pulse.
REQ-023 WAIT: on txDone=1, increment the char index; if the index was 3 with TERM_EN=0, or 4 with TERM_EN=1, the word is complete, wordsSent increments, and -> IDLE; otherwise -> ENCODE.
REQ-024 txDone outside WAIT SHALL be ignored.
REQ-025 Latency: the first txDataValid occurs 4 cycles after the IDLE cycle that sees enable=1 and fifoEmpty=0, provided txActive=0.
REQ-026 Minimum gap between words: one IDLE cycle; back-to-back words do not skip IDLE.
REQ-027 fifoReadStrobe SHALL never assert while fifoEmpty=1, nor more than once per word.
REQ-028 enable deasserted mid-word SHALL NOT abort the word; the word completes and the block then stays in IDLE.
REQ-029 fifoEmpty rising after FETCH SHALL NOT affect the word already fetched.
REQ-030 wordsSent wraps 16'hFFFF -> 16'h0000 without saturation or flag.
REQ-031 Exactly 4 (TERM_EN=0) or 5 (TERM_EN=1) txDataValid pulses SHALL be issued per fetched word.

Reset
REQ-032 With rst=1 at a rising edge: state=IDLE, char index=0, word register=0, wordsSent=0, txDataByte=8'h00, txDataValid=0, fifoReadStrobe=0, busy=0.
REQ-033 Reset mid-word SHALL discard the remaining characters of that word with no increment of wordsSent; the FIFO entry already read is lost.
REQ-034 During reset, txDone and fifoEmpty are ignored; operation resumes from IDLE on the first cycle with rst=0.

Verification
REQ-035 Defaults, FIFO holds 16'hBEEF, UART model with a 10-cycle txActive then txDone -> bytes 42 45 45 46 0A in order, one fifoReadStrobe, wordsSent=1.
REQ-036 UPPERCASE=0, TERM_EN=0, word 16'h0A5F -> bytes 30 61 35 66 only, 4 txDataValid pulses, wordsSent=1.
REQ-037 Words 16'h1234, 16'hFFFF queued back-to-back -> 31 32 33 34 0A 46 46 46 46 0A, exactly one IDLE cycle between the words, wordsSent=2.
REQ-038 txActive held high for 50 cycles on entry to SEND -> no txDataValid until txActive falls, then one pulse; txDataByte stable until txDone.
REQ-039 rst pulsed after the second character of 16'hC0DE -> all outputs reach reset values the next cycle, wordsSent=0; the next queued word 16'h0001 is sent as 30 30 30 31 0A.
REQ-040 wordsSent preloaded to 16'hFFFF via 65535 words (or forced) then one more word -> wordsSent=16'h0000; enable=0 with a non-empty FIFO -> no fifoReadStrobe for 100 cycles.
